next_pc_unit: RTL and testbench
===============================

Name: next_pc_unit

Overview:
- Producer side of the program counter interface: takes the current PC and control-unit decisions, drives Next_PC back into the PC register every cycle.
- Handles sequential increment, relative branches, absolute jumps, and call/return through an internal return-address stack.
- Has a small RUN/HALT/FAULT state machine that freezes the PC on a halt request or a stack error.
- Sits between the control unit and the program counter in the single-cycle datapath.

Parameters:
- ADDR_W, 8, width of PC, Next_PC and all address fields.
- DEPTH, 4, number of return-address stack entries (power of two, ≥2).

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Clear_n  input  1  asynchronous active-low reset.
- PC  input  ADDR_W  current program counter value.
- Stall  input  1  hold the PC; no stack update this cycle.
- Halt  input  1  request to enter HALT.
- Branch_Taken  input  1  take the relative branch.
- Branch_Offset  input  ADDR_W  two's-complement signed offset, relative to PC+1.
- Jump  input  1  absolute jump to Jump_Target.
- Call  input  1  push PC+1, then jump to Jump_Target.
- Ret  input  1  pop the stack top into Next_PC.
- Jump_Target  input  ADDR_W  absolute target for Jump and Call.
- Next_PC  output  ADDR_W  next PC value, combinational.
- Stack_Depth  output  clog2(DEPTH)+1  number of valid stack entries.
- Halted  output  1  state is HALT.
- Fault  output  1  state is FAULT.
- Overflow  output  1  sticky: a Call was issued with the stack full.
- Underflow  output  1  sticky: a Ret was issued with the stack empty.

Behaviour:
- Reset: Clock is Clk; reset is Clear_n, asynchronous and active-low.
  - While Clear_n=0: state=RUN, Stack_Depth=0, Overflow=0, Underflow=0, and Next_PC=0.
  - Stack contents are don't-care after reset.
- States: RUN, HALT, FAULT. Halted=(state==HALT) and Fault=(state==FAULT).
- Next_PC is combinational with zero latency. Stack, flags and state update on the rising edge of Clk.
- In HALT or FAULT:
  - Next_PC=PC.
  - All command inputs are ignored.
  - Only Clear_n leaves these states.
- In RUN, priority is highest first:
  - Stall: Next_PC=PC. No stack change, and Halt is ignored.
  - Halt: Next_PC=PC. Next state is HALT.
  - Ret:
    - Depth>0: Next_PC=top entry, pop, Depth-1.
    - Depth==0: Next_PC=PC. Underflow is set, next state is FAULT.
  - Call:
    - Depth<DEPTH: push (PC+1) mod 2^ADDR_W, Next_PC=Jump_Target, Depth+1.
    - Depth==DEPTH: Next_PC=PC, no push. Overflow is set, next state is FAULT.
  - Jump: Next_PC=Jump_Target.
  - Branch_Taken: Next_PC=(PC+1+Branch_Offset) mod 2^ADDR_W, with sign-extended add and wrap-around.
  - Otherwise: Next_PC=(PC+1) mod 2^ADDR_W, so 8'hFF wraps to 8'h00.
- Simultaneous commands: only the highest-priority one acts. For example, Call+Ret together performs Ret only.
- Stack organisation: LIFO, a register array plus a pointer. Push writes to entry[Depth]; top is entry[Depth-1].
- Overflow and Underflow stay set until Clear_n.
- Reset mid-operation:
  - The stack is emptied immediately (asynchronously).
  - The first rising edge after Clear_n rises behaves as RUN with an empty stack.

Test Plan:
- Reset, PC=8'h10, no commands -> Next_PC=8'h11. PC=8'hFF -> Next_PC=8'h00.
- PC=8'h20, Branch_Taken=1, Branch_Offset=8'hFB (−5) -> Next_PC=8'h1C. With Offset=8'h05 -> 8'h26.
- PC=8'h30, Call=1, Jump_Target=8'h80 -> Next_PC=8'h80, Depth=1. Next cycle PC=8'h85, Ret=1 -> Next_PC=8'h31, Depth=0.
- Four nested Calls (DEPTH=4), then a fifth Call at PC=8'h44 -> Next_PC=8'h44, Overflow=1, Fault=1. Subsequent Jump is ignored; Next_PC tracks PC.
- Ret with empty stack at PC=8'h50 -> Next_PC=8'h50, Underflow=1, Fault=1. Pulse Clear_n low mid-cycle -> Fault=0, flags=0, Depth=0 immediately, without a clock edge.
- Stall=1 together with Call=1 at PC=8'h60 -> Next_PC=8'h60, Depth unchanged. Then Halt=1 -> Halted=1, and Next_PC=PC indefinitely regardless of commands.

Source files
------------

// File: rtl/next_pc_if.sv
// Control-unit / PC-register bus for the next-PC unit.
interface next_pc_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned DEPTH_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]  PC;
  logic               Stall;
  logic               Halt;
  logic               Branch_Taken;
  logic [ADDR_W-1:0]  Branch_Offset;
  logic               Jump;
  logic               Call;
  logic               Ret;
  logic [ADDR_W-1:0]  Jump_Target;
  logic [ADDR_W-1:0]  Next_PC;
  logic [DEPTH_W-1:0] Stack_Depth;
  logic               Halted;
  logic               Fault;
  logic               Overflow;
  logic               Underflow;

  // Control side: drives PC and commands, observes the result.
  modport master (
    output PC, Stall, Halt, Branch_Taken, Branch_Offset, Jump, Call, Ret, Jump_Target,
    input  Next_PC, Stack_Depth, Halted, Fault, Overflow, Underflow
  );

  // Next-PC unit side.
  modport slave (
    input  PC, Stall, Halt, Branch_Taken, Branch_Offset, Jump, Call, Ret, Jump_Target,
    output Next_PC, Stack_Depth, Halted, Fault, Overflow, Underflow
  );
endinterface

// File: rtl/next_pc_unit.sv
// Next-PC selection with return-address stack and RUN/HALT/FAULT control.
module next_pc_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic     Clk,
  input  logic     Clear_n,
  next_pc_if.slave bus
);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned DEPTH_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               push;
  logic [ADDR_W-1:0]  stack_q [DEPTH];
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  top;
  logic [ADDR_W-1:0]  next_pc;

  assign pc_inc = bus.PC + ADDR_W'(1);
  assign top    = stack_q[PTR_W'(depth_q - DEPTH_W'(1))];

  // State, depth and sticky-flag registers; reset empties the stack at once.
  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q <= S_RUN;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage; contents need no reset since depth gates every read.
  always_ff @(posedge Clk) begin
    if (push) stack_q[PTR_W'(depth_q)] <= pc_inc;
  end

  // Priority-ordered command decode: next state, stack action and Next_PC.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    next_pc = bus.PC;
    case (state_q)
      S_RUN: begin
        if (bus.Stall) begin
          next_pc = bus.PC;
        end else if (bus.Halt) begin
          state_d = S_HALT;
        end else if (bus.Ret) begin
          if (depth_q != '0) begin
            next_pc = top;
            depth_d = depth_q - DEPTH_W'(1);
          end else begin
            unf_d   = 1'b1;
            state_d = S_FAULT;
          end
        end else if (bus.Call) begin
          if (depth_q != DEPTH_W'(DEPTH)) begin
            push    = 1'b1;
            next_pc = bus.Jump_Target;
            depth_d = depth_q + DEPTH_W'(1);
          end else begin
            ovf_d   = 1'b1;
            state_d = S_FAULT;
          end
        end else if (bus.Jump) begin
          next_pc = bus.Jump_Target;
        end else if (bus.Branch_Taken) begin
          next_pc = pc_inc + bus.Branch_Offset;
        end else begin
          next_pc = pc_inc;
        end
      end
      default: next_pc = bus.PC;
    endcase
    if (!Clear_n) next_pc = '0;
  end

  assign bus.Next_PC     = next_pc;
  assign bus.Stack_Depth = depth_q;
  assign bus.Halted      = (state_q == S_HALT);
  assign bus.Fault       = (state_q == S_FAULT);
  assign bus.Overflow    = ovf_q;
  assign bus.Underflow   = unf_q;
endmodule

// File: tb/tb_next_pc_unit.sv
// Directed scoreboard bench for next_pc_unit.
module tb_next_pc_unit;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 4;

  typedef struct {
    string      tag;
    logic [7:0] npc;
    logic [2:0] depth;
    logic [3:0] flags;  // {Halted, Fault, Overflow, Underflow}
  } exp_t;

  logic Clk;
  logic Clear_n;
  int   checks;
  int   errors;
  exp_t sb [$];

  next_pc_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  next_pc_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .Clk     (Clk),
    .Clear_n (Clear_n),
    .bus     (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Compare the oldest scoreboard entry against the DUT outputs.
  task automatic check_out();
    exp_t e;
    logic [3:0] f;
    e = sb.pop_front();
    f = {bus.Halted, bus.Fault, bus.Overflow, bus.Underflow};
    checks++;
    assert (bus.Next_PC === e.npc) else begin
      errors++;
      $error("FAIL %s next_pc got %h want %h", e.tag, bus.Next_PC, e.npc);
    end
    checks++;
    assert (bus.Stack_Depth === e.depth) else begin
      errors++;
      $error("FAIL %s depth got %0d want %0d", e.tag, bus.Stack_Depth, e.depth);
    end
    checks++;
    assert (f === e.flags) else begin
      errors++;
      $error("FAIL %s flags got %b want %b", e.tag, f, e.flags);
    end
  endtask

  // cmd = {Stall, Halt, Ret, Call, Jump, Branch_Taken}; registered expectations
  // describe the state before this cycle's clock edge.
  task automatic step(input string tag, input logic clr, input logic [7:0] pc,
                      input logic [5:0] cmd, input logic [7:0] off, input logic [7:0] tgt,
                      input logic [7:0] e_npc, input logic [2:0] e_depth, input logic [3:0] e_flags);
    exp_t e;
    @(negedge Clk);
    Clear_n            = clr;
    bus.PC             = pc;
    {bus.Stall, bus.Halt, bus.Ret, bus.Call, bus.Jump, bus.Branch_Taken} = cmd;
    bus.Branch_Offset  = off;
    bus.Jump_Target    = tgt;
    e.tag = tag; e.npc = e_npc; e.depth = e_depth; e.flags = e_flags;
    sb.push_back(e);
    #1;
    check_out();
  endtask

  localparam logic [5:0] NONE = 6'b000000, BR = 6'b000001, JMP = 6'b000010,
                         CALL = 6'b000100, RET = 6'b001000, HALT = 6'b010000,
                         STALL = 6'b100000;

  initial begin
    checks = 0;
    errors = 0;
    Clear_n = 1'b1;
    bus.PC = '0; bus.Stall = 0; bus.Halt = 0; bus.Branch_Taken = 0;
    bus.Branch_Offset = '0; bus.Jump = 0; bus.Call = 0; bus.Ret = 0; bus.Jump_Target = '0;
    #2 Clear_n = 1'b0;

    step("reset",      0, 8'h33, CALL,       8'h00, 8'h80, 8'h00, 0, 4'b0000);
    step("seq",        1, 8'h10, NONE,       8'h00, 8'h00, 8'h11, 0, 4'b0000);
    step("wrap",       1, 8'hFF, NONE,       8'h00, 8'h00, 8'h00, 0, 4'b0000);
    step("br_neg",     1, 8'h20, BR,         8'hFB, 8'h00, 8'h1C, 0, 4'b0000);
    step("br_pos",     1, 8'h20, BR,         8'h05, 8'h00, 8'h26, 0, 4'b0000);
    step("jump",       1, 8'h40, JMP|BR,     8'h05, 8'h77, 8'h77, 0, 4'b0000);
    step("call",       1, 8'h30, CALL|JMP,   8'h00, 8'h80, 8'h80, 0, 4'b0000);
    step("ret",        1, 8'h85, RET,        8'h00, 8'h00, 8'h31, 1, 4'b0000);
    step("after_ret",  1, 8'h31, NONE,       8'h00, 8'h00, 8'h32, 0, 4'b0000);
    // Two-level LIFO and Call+Ret priority
    step("call_a",     1, 8'h10, CALL,       8'h00, 8'h80, 8'h80, 0, 4'b0000);
    step("call_b",     1, 8'h80, CALL,       8'h00, 8'hC0, 8'hC0, 1, 4'b0000);
    step("call_ret",   1, 8'h11, CALL|RET,   8'h00, 8'hEE, 8'h81, 2, 4'b0000);
    step("ret_a",      1, 8'h81, RET,        8'h00, 8'h00, 8'h11, 1, 4'b0000);
    step("empty",      1, 8'h12, NONE,       8'h00, 8'h00, 8'h13, 0, 4'b0000);
    // Overflow into FAULT
    step("nest1",      1, 8'h01, CALL,       8'h00, 8'hA0, 8'hA0, 0, 4'b0000);
    step("nest2",      1, 8'h02, CALL,       8'h00, 8'hA0, 8'hA0, 1, 4'b0000);
    step("nest3",      1, 8'h03, CALL,       8'h00, 8'hA0, 8'hA0, 2, 4'b0000);
    step("nest4",      1, 8'h04, CALL,       8'h00, 8'hA0, 8'hA0, 3, 4'b0000);
    step("ovf_call",   1, 8'h44, CALL,       8'h00, 8'hA0, 8'h44, 4, 4'b0000);
    step("fault_jmp",  1, 8'h55, JMP,        8'h00, 8'h99, 8'h55, 4, 4'b0110);
    step("fault_hold", 1, 8'h56, RET,        8'h00, 8'h00, 8'h56, 4, 4'b0110);
    // Asynchronous clear mid-cycle
    step("async_clr",  0, 8'h57, NONE,       8'h00, 8'h00, 8'h00, 0, 4'b0000);
    step("post_clr",   1, 8'h57, NONE,       8'h00, 8'h00, 8'h58, 0, 4'b0000);
    // Underflow into FAULT
    step("unf_ret",    1, 8'h50, RET,        8'h00, 8'h00, 8'h50, 0, 4'b0000);
    step("unf_fault",  1, 8'h51, CALL,       8'h00, 8'h80, 8'h51, 0, 4'b0101);
    step("unf_clr",    0, 8'h52, NONE,       8'h00, 8'h00, 8'h00, 0, 4'b0000);
    // Stall priority, then HALT
    step("stall_call", 1, 8'h60, STALL|CALL, 8'h00, 8'h90, 8'h60, 0, 4'b0000);
    step("stall_halt", 1, 8'h60, STALL|HALT, 8'h00, 8'h90, 8'h60, 0, 4'b0000);
    step("halt",       1, 8'h60, HALT,       8'h00, 8'h00, 8'h60, 0, 4'b0000);
    step("halt_call",  1, 8'h61, CALL|JMP,   8'h00, 8'h90, 8'h61, 0, 4'b1000);
    step("halt_ret",   1, 8'h62, RET,        8'h00, 8'h00, 8'h62, 0, 4'b1000);
    step("halt_seq",   1, 8'h63, NONE,       8'h00, 8'h00, 8'h63, 0, 4'b1000);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
